// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order write-back FIFO feeding the register-file write port
//
// Purpose: buffers result writes from the memory/load unit and the ALU in
// acceptance order and retires one per cycle onto the register file. Decode
// can look up pending writes by register number for forwarding.
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   AluValid/AluRD/AluData       ALU write request; AluReady = accepted this edge
//   MemValid/MemRD/MemData       load write request; MemReady = accepted this edge
//   Hold                         register-file port busy, blocks retirement
//   RD/WriteData/RegWrite        register-file write port (head entry)
//   RS/RT                        decode lookup addresses
//   FwdRSHit/FwdRSData           newest pending write to RS
//   FwdRTHit/FwdRTData           newest pending write to RT
//   Count/Full/Empty             occupancy
module writeback_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     AluValid,
   input  logic [ADDR_W-1:0]        AluRD,
   input  logic [DATA_W-1:0]        AluData,
   output logic                     AluReady,
   input  logic                     MemValid,
   input  logic [ADDR_W-1:0]        MemRD,
   input  logic [DATA_W-1:0]        MemData,
   output logic                     MemReady,
   input  logic                     Hold,
   output logic [ADDR_W-1:0]        RD,
   output logic [DATA_W-1:0]        WriteData,
   output logic                     RegWrite,
   input  logic [ADDR_W-1:0]        RS,
   input  logic [ADDR_W-1:0]        RT,
   output logic                     FwdRSHit,
   output logic                     FwdRTHit,
   output logic [DATA_W-1:0]        FwdRSData,
   output logic [DATA_W-1:0]        FwdRTData,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Full,
   output logic                     Empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_rd;
   logic [DATA_W-1:0] push_data;

   assign Count = count_q;
   assign Full  = (count_q == (PTR_W+1)'(DEPTH));
   assign Empty = (count_q == '0);

   // Readiness looks only at the registered Full flag, so a pop on this
   // edge never makes room for a push on the same edge.
   assign MemReady = !Full;
   assign AluReady = !Full && !MemValid;

   // Loads are older in program order, so they win the single enqueue slot.
   assign push      = !Reset && !Full && (MemValid || AluValid);
   assign push_rd   = MemValid ? MemRD   : AluRD;
   assign push_data = MemValid ? MemData : AluData;

   // The reset cycle must not commit anything that is about to be discarded.
   assign RegWrite  = !Empty && !Hold && !Reset;
   assign pop       = RegWrite;

   assign RD        = Empty ? '0 : rd_mem_q[rd_ptr_q];
   assign WriteData = Empty ? '0 : data_mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the wrap-around.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: only slots inside [rd_ptr, rd_ptr+count)
   // are ever observed.
   always_ff @(posedge Clock) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= push_rd;
         data_mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Walk valid entries oldest to newest; a later match overrides an earlier
   // one so the newest pending value is forwarded.
   always_comb begin
      FwdRSHit  = 1'b0;
      FwdRTHit  = 1'b0;
      FwdRSData = '0;
      FwdRTData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((PTR_W+1)'(i) < count_q) begin
            if (rd_mem_q[rd_ptr_q + PTR_W'(i)] == RS) begin
               FwdRSHit  = 1'b1;
               FwdRSData = data_mem_q[rd_ptr_q + PTR_W'(i)];
            end
            if (rd_mem_q[rd_ptr_q + PTR_W'(i)] == RT) begin
               FwdRTHit  = 1'b1;
               FwdRTData = data_mem_q[rd_ptr_q + PTR_W'(i)];
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - testbench for writeback_queue
module tb_writeback_queue;

   logic        Clock = 1'b0;
   logic        Reset, AluValid, MemValid, Hold;
   logic [4:0]  AluRD, MemRD, RS, RT, RD;
   logic [15:0] AluData, MemData, WriteData, FwdRSData, FwdRTData;
   logic        AluReady, MemReady, RegWrite, FwdRSHit, FwdRTHit, Full, Empty;
   logic [2:0]  Count;

   writeback_queue #(.DATA_W(16), .ADDR_W(5), .DEPTH(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData), .AluReady(AluReady),
      .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData), .MemReady(MemReady),
      .Hold(Hold), .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
      .RS(RS), .RT(RT), .FwdRSHit(FwdRSHit), .FwdRTHit(FwdRTHit),
      .FwdRSData(FwdRSData), .FwdRTData(FwdRTData),
      .Count(Count), .Full(Full), .Empty(Empty)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int rst, hold, av, ard, ad, mv, mrd, md, rs, rt;
      int e_rw, e_rd, e_wd, e_cnt, e_ar, e_mr, e_sh, e_sd, e_th, e_td;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int rst, hold, av, ard, ad, mv, mrd, md, rs, rt,
                      input int e_rw, e_rd, e_wd, e_cnt, e_ar, e_mr, e_sh, e_sd, e_th, e_td);
      vec_t v;
      v = '{rst, hold, av, ard, ad, mv, mrd, md, rs, rt,
            e_rw, e_rd, e_wd, e_cnt, e_ar, e_mr, e_sh, e_sd, e_th, e_td};
      vq.push_back(v);
   endtask

   task automatic drive(input int rst, hold, av, ard, ad, mv, mrd, md, rs, rt);
      Reset    = (rst != 0);
      Hold     = (hold != 0);
      AluValid = (av != 0);
      AluRD    = 5'(ard);
      AluData  = 16'(ad);
      MemValid = (mv != 0);
      MemRD    = 5'(mrd);
      MemData  = 16'(md);
      RS       = 5'(rs);
      RT       = 5'(rt);
   endtask

   // Behavioural reference: a plain queue of pending {rd, data} writes.
   typedef struct { int rd; int d; } ent_t;
   ent_t mq[$];

   task automatic mstep(input int rst, hold, av, ard, ad, mv, mrd, md, rs, rt);
      int sz, rw, full, acc, sh, sd, th, td;
      ent_t e;
      drive(rst, hold, av, ard, ad, mv, mrd, md, rs, rt);
      #2;
      sz   = mq.size();
      full = (sz == 4);
      rw   = (rst == 0 && sz > 0 && hold == 0);
      sh = 0; sd = 0; th = 0; td = 0;
      foreach (mq[i]) begin
         if (mq[i].rd == rs) begin sh = 1; sd = mq[i].d; end
         if (mq[i].rd == rt) begin th = 1; td = mq[i].d; end
      end
      chk("m_count", int'(Count), sz);
      chk("m_full", int'(Full), full);
      chk("m_empty", int'(Empty), int'(sz == 0));
      chk("m_regwrite", int'(RegWrite), rw);
      chk("m_rd", int'(RD), sz > 0 ? mq[0].rd : 0);
      chk("m_wdata", int'(WriteData), sz > 0 ? mq[0].d : 0);
      chk("m_memready", int'(MemReady), int'(!full));
      chk("m_aluready", int'(AluReady), int'(!full && mv == 0));
      chk("m_rs_hit", int'(FwdRSHit), sh);
      chk("m_rs_data", int'(FwdRSData), sd);
      chk("m_rt_hit", int'(FwdRTHit), th);
      chk("m_rt_data", int'(FwdRTData), td);
      @(posedge Clock);
      acc = (rst == 0 && !full && (av != 0 || mv != 0));
      if (rst != 0) mq.delete();
      else begin
         if (rw != 0) void'(mq.pop_front());
         if (acc != 0) begin
            e.rd = (mv != 0) ? mrd : ard;
            e.d  = (mv != 0) ? md  : ad;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge Clock);
      #1;

      //   rst hold av ard ad      mv mrd md  rs rt | rw rd wd      cnt ar mr sh sd      th td
      add(0, 0, 0, 0, 0,       0, 0, 0,  0, 1,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 0, 1, 3, 'h000B,  0, 0, 0,  3, 1,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  3, 1,     1, 3, 'h000B,  1, 1, 1, 1, 'h000B,  0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  3, 1,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 0, 1, 3, 1,       1, 8, 15, 8, 3,     0, 0, 0,       0, 0, 1, 0, 0,       0, 0);
      add(0, 0, 1, 3, 1,       0, 0, 0,  8, 3,     1, 8, 15,      1, 1, 1, 1, 15,      0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  8, 3,     1, 3, 1,       1, 1, 1, 0, 0,       1, 1);
      add(0, 0, 0, 0, 0,       0, 0, 0,  8, 3,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 8, 'hAAAA,  0, 0, 0,  8, 9,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 8, 'hBBBB,  0, 0, 0,  8, 9,     0, 8, 'hAAAA,  1, 1, 1, 1, 'hAAAA,  0, 0);
      add(0, 1, 0, 0, 0,       0, 0, 0,  8, 9,     0, 8, 'hAAAA,  2, 1, 1, 1, 'hBBBB,  0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  8, 9,     1, 8, 'hAAAA,  2, 1, 1, 1, 'hBBBB,  0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  8, 9,     1, 8, 'hBBBB,  1, 1, 1, 1, 'hBBBB,  0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  8, 9,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 1, 1,       0, 0, 0,  0, 0,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 2, 2,       0, 0, 0,  0, 0,     0, 1, 1,       1, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 3, 3,       0, 0, 0,  0, 0,     0, 1, 1,       2, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 4, 4,       0, 0, 0,  0, 0,     0, 1, 1,       3, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 5, 5,       0, 0, 0,  0, 0,     0, 1, 1,       4, 0, 0, 0, 0,       0, 0);
      add(0, 0, 1, 5, 5,       0, 0, 0,  0, 0,     1, 1, 1,       4, 0, 0, 0, 0,       0, 0);
      add(0, 0, 1, 5, 5,       0, 0, 0,  0, 0,     1, 2, 2,       3, 1, 1, 0, 0,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  0, 0,     1, 3, 3,       3, 1, 1, 0, 0,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  0, 0,     1, 4, 4,       2, 1, 1, 0, 0,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  5, 0,     1, 5, 5,       1, 1, 1, 1, 5,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  5, 0,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 7, 7,       0, 0, 0,  0, 0,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 9, 9,       0, 0, 0,  0, 0,     0, 7, 7,       1, 1, 1, 0, 0,       0, 0);
      add(0, 1, 1, 10, 10,     0, 0, 0,  0, 0,     0, 7, 7,       2, 1, 1, 0, 0,       0, 0);
      add(1, 0, 0, 0, 0,       0, 0, 0,  7, 0,     0, 7, 7,       3, 1, 1, 1, 7,       0, 0);
      add(0, 0, 0, 0, 0,       0, 0, 0,  7, 0,     0, 0, 0,       0, 1, 1, 0, 0,       0, 0);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].hold, vq[i].av, vq[i].ard, vq[i].ad,
               vq[i].mv, vq[i].mrd, vq[i].md, vq[i].rs, vq[i].rt);
         #2;
         chk($sformatf("v%0d_regwrite", i), int'(RegWrite), vq[i].e_rw);
         chk($sformatf("v%0d_rd", i), int'(RD), vq[i].e_rd);
         chk($sformatf("v%0d_wdata", i), int'(WriteData), vq[i].e_wd);
         chk($sformatf("v%0d_count", i), int'(Count), vq[i].e_cnt);
         chk($sformatf("v%0d_full", i), int'(Full), int'(vq[i].e_cnt == 4));
         chk($sformatf("v%0d_empty", i), int'(Empty), int'(vq[i].e_cnt == 0));
         chk($sformatf("v%0d_aluready", i), int'(AluReady), vq[i].e_ar);
         chk($sformatf("v%0d_memready", i), int'(MemReady), vq[i].e_mr);
         chk($sformatf("v%0d_rs_hit", i), int'(FwdRSHit), vq[i].e_sh);
         chk($sformatf("v%0d_rs_data", i), int'(FwdRSData), vq[i].e_sd);
         chk($sformatf("v%0d_rt_hit", i), int'(FwdRTHit), vq[i].e_th);
         chk($sformatf("v%0d_rt_data", i), int'(FwdRTData), vq[i].e_td);
         @(posedge Clock);
         #1;
      end

      // Model-tracked sequences start from a clean reset.
      mq.delete();
      mstep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Three entries pending, then continuous ALU pushes with Hold low:
      // occupancy must stay at 3 and retirement order must match acceptance.
      for (int i = 0; i < 3; i++) mstep(0, 1, 1, 20 + i, 'h100 + i, 0, 0, 0, 21, 22);
      for (int i = 0; i < 8; i++) begin
         mstep(0, 0, 1, 23 + (i % 4), 'h200 + i, 0, 0, 0, 24, 21);
         chk("steady_count", int'(Count), 3);
      end
      for (int i = 0; i < 4; i++) mstep(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic against the reference queue.
      for (int i = 0; i < 600; i++) begin
         mstep(int'($urandom_range(0, 59) == 0), int'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
               int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
